// File: rtl/calendar_set_ctrl.sv
// Set-mode front end for the calendar counter: mode FSM, increment pulses, deferred rollover, field blink.
// Build option: define CAL_AUTO_REPEAT_EN to compile in hold-to-repeat on key_inc.
module calendar_set_ctrl #(
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter int unsigned BLINK_CYCLES  = 25_000_000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       full_flag_in,
    output logic [2:0] cnt_inc,
    output logic       full_flag,
    output logic       set_mode,
    output logic [1:0] sel,
    output logic       blink
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_DAY  = 2'd1,
        SET_MON  = 2'd2,
        SET_YEAR = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        key_mode_d, key_inc_d;
    logic        mode_rise, inc_rise, rep_fire;
    logic        pending, pending_nxt;
    logic        blink_phase, blink_phase_nxt;
    logic [31:0] blink_cnt, blink_cnt_nxt;
    logic [2:0]  cnt_inc_nxt;
    logic        full_flag_nxt, blink_nxt;

    assign mode_rise = key_mode & ~key_mode_d;
    assign inc_rise  = key_inc & ~key_inc_d;

`ifdef CAL_AUTO_REPEAT_EN
    logic [31:0] hold_cnt, hold_cnt_nxt;
    logic [31:0] rep_cnt, rep_cnt_nxt;

    // Hold counter saturates at HOLD_CYCLES; from then on rep_cnt paces the repeats.
    always_comb begin
        hold_cnt_nxt = hold_cnt;
        rep_cnt_nxt  = rep_cnt;
        rep_fire     = 1'b0;
        if (!key_inc || mode_rise || state == RUN) begin
            hold_cnt_nxt = 32'd0;
            rep_cnt_nxt  = 32'd0;
        end else if (hold_cnt < HOLD_CYCLES) begin
            hold_cnt_nxt = hold_cnt + 32'd1;
        end else begin
            rep_fire    = (rep_cnt == 32'd0);
            rep_cnt_nxt = (rep_cnt == REPEAT_CYCLES - 1) ? 32'd0 : rep_cnt + 32'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_cnt <= 32'd0;
            rep_cnt  <= 32'd0;
        end else begin
            hold_cnt <= hold_cnt_nxt;
            rep_cnt  <= rep_cnt_nxt;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        state_nxt       = state;
        cnt_inc_nxt     = 3'b000;
        full_flag_nxt   = 1'b0;
        pending_nxt     = pending;
        blink_cnt_nxt   = blink_cnt;
        blink_phase_nxt = blink_phase;

        if (mode_rise) begin
            case (state)
                RUN:      state_nxt = SET_DAY;
                SET_DAY:  state_nxt = SET_MON;
                SET_MON:  state_nxt = SET_YEAR;
                default:  state_nxt = RUN;
            endcase
        end

        // A mode edge in the same cycle swallows any increment.
        if (state != RUN && !mode_rise && (inc_rise || rep_fire)) begin
            case (state)
                SET_DAY:  cnt_inc_nxt = 3'b001;
                SET_MON:  cnt_inc_nxt = 3'b010;
                default:  cnt_inc_nxt = 3'b100;
            endcase
        end

        // Carries seen in set mode collapse into one pulse, flushed on the first RUN cycle.
        full_flag_nxt = (state == RUN) && (pending || full_flag_in);
        pending_nxt   = (state != RUN) && (pending || full_flag_in);

        if (mode_rise || state == RUN) begin
            blink_cnt_nxt   = 32'd0;
            blink_phase_nxt = 1'b0;
        end else if (blink_cnt == BLINK_CYCLES - 1) begin
            blink_cnt_nxt   = 32'd0;
            blink_phase_nxt = ~blink_phase;
        end else begin
            blink_cnt_nxt   = blink_cnt + 32'd1;
        end

        blink_nxt = (state_nxt != RUN) && blink_phase_nxt && !key_inc;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= RUN;
            key_mode_d  <= 1'b0;
            key_inc_d   <= 1'b0;
            pending     <= 1'b0;
            blink_cnt   <= 32'd0;
            blink_phase <= 1'b0;
            cnt_inc     <= 3'b000;
            full_flag   <= 1'b0;
            set_mode    <= 1'b0;
            sel         <= 2'd0;
            blink       <= 1'b0;
        end else begin
            state       <= state_nxt;
            key_mode_d  <= key_mode;
            key_inc_d   <= key_inc;
            pending     <= pending_nxt;
            blink_cnt   <= blink_cnt_nxt;
            blink_phase <= blink_phase_nxt;
            cnt_inc     <= cnt_inc_nxt;
            full_flag   <= full_flag_nxt;
            set_mode    <= (state_nxt != RUN);
            sel         <= state_nxt;
            blink       <= blink_nxt;
        end
    end

endmodule
